// File: rtl/call_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : call_stack_ctrl
//  Purpose  : LIFO call/return stack with a registered pop port, a
//             combinational peek of the top entry, and sticky overflow and
//             underflow flags. When full, a call either drops the push
//             (WRAP_MODE=0) or overwrites the oldest entry by advancing a
//             circular base pointer (WRAP_MODE=1).
//  Ports    : clock_i / reset_i  - clock, synchronous active-high reset
//             call_i, ret_i      - push / pop requests (sampled each cycle)
//             flush_i            - empty the stack
//             err_clear_i        - clear the sticky error flags
//             call_data_i        - entry to push
//             ret_data_o         - registered popped entry
//             ret_valid_o        - one-cycle strobe, ret_data_o updated
//             top_data_o         - peek of the top entry (0 when empty)
//             count_o            - number of valid entries, 0..DEPTH
//             full_o, empty_o    - count_o == DEPTH / count_o == 0
//             overflow_o         - sticky: call while full
//             underflow_o        - sticky: ret while empty without call
//  Revision : 1.0 - initial release
// ============================================================================
module call_stack_ctrl #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 8,
  parameter bit WRAP_MODE = 1'b0,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              call_i,
  input  logic              ret_i,
  input  logic              flush_i,
  input  logic              err_clear_i,
  input  logic [DATA_W-1:0] call_data_i,
  output logic [DATA_W-1:0] ret_data_o,
  output logic              ret_valid_o,
  output logic [DATA_W-1:0] top_data_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  // Storage is not reset; an entry is only read while it is valid.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]     base_q,      base_d;   // index of the oldest entry
  logic [CW-1:0]     count_q,     count_d;
  logic [DATA_W-1:0] ret_data_q,  ret_data_d;
  logic              ret_valid_q, ret_valid_d;
  logic              ovf_q,       ovf_d;
  logic              unf_q,       unf_d;

  logic              w_full;
  logic              w_empty;
  logic [PW-1:0]     w_push_idx;
  logic [PW-1:0]     w_top_idx;
  logic              w_we;
  logic [PW-1:0]     w_waddr;

  assign w_full  = (count_q == CW'(DEPTH));
  assign w_empty = (count_q == '0);

  // Free slot above the top. When full the low count bits are zero, so this
  // lands on base_q, which is exactly the slot a wrapping push overwrites.
  assign w_push_idx = base_q + count_q[PW-1:0];
  assign w_top_idx  = w_push_idx - PW'(1);

  always_comb begin
    count_d     = count_q;
    base_d      = base_q;
    ret_data_d  = ret_data_q;
    ret_valid_d = 1'b0;
    ovf_d       = err_clear_i ? 1'b0 : ovf_q;
    unf_d       = err_clear_i ? 1'b0 : unf_q;
    w_we        = 1'b0;
    w_waddr     = w_push_idx;

    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({call_i, ret_i})
        2'b10: begin
          if (!w_full) begin
            w_we    = 1'b1;
            count_d = count_q + CW'(1);
          end else if (WRAP_MODE) begin
            // Overwrite the oldest entry; it becomes the new top and the
            // next-oldest becomes the base.
            w_we    = 1'b1;
            w_waddr = base_q;
            base_d  = base_q + PW'(1);
            ovf_d   = 1'b1;
          end else begin
            ovf_d   = 1'b1;
          end
        end
        2'b01: begin
          if (!w_empty) begin
            ret_data_d  = mem_q[w_top_idx];
            ret_valid_d = 1'b1;
            count_d     = count_q - CW'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        2'b11: begin
          ret_valid_d = 1'b1;
          if (!w_empty) begin
            // Swap the top entry: pop the old value, write the new one.
            ret_data_d = mem_q[w_top_idx];
            w_we       = 1'b1;
            w_waddr    = w_top_idx;
          end else begin
            ret_data_d = call_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      base_q      <= '0;
      count_q     <= '0;
      ret_data_q  <= '0;
      ret_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      base_q      <= base_d;
      count_q     <= count_d;
      ret_data_q  <= ret_data_d;
      ret_valid_q <= ret_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_we && !reset_i) begin
      mem_q[w_waddr] <= call_data_i;
    end
  end

  assign ret_data_o  = ret_data_q;
  assign ret_valid_o = ret_valid_q;
  assign top_data_o  = w_empty ? '0 : mem_q[w_top_idx];
  assign count_o     = count_q;
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_call_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_call_stack_ctrl
//  Purpose  : Directed self-checking bench. Two instances (drop-on-full and
//             wrap-on-full) share one stimulus stream; expected pops are
//             queued when a ret is driven and compared on the strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_call_stack_ctrl;

  localparam int DW = 4;
  localparam int DP = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          call, ret, flush, errc;
  logic [DW-1:0] cdata;

  logic [DW-1:0] rd0, td0, rd1, td1;
  logic          rv0, fu0, em0, ov0, un0;
  logic          rv1, fu1, em1, ov1, un1;
  logic [CW-1:0] cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  always #5 clk = ~clk;

  call_stack_ctrl #(.DATA_W(DW), .DEPTH(DP), .WRAP_MODE(1'b0)) u_dut0 (
    .clock_i(clk), .reset_i(rst), .call_i(call), .ret_i(ret), .flush_i(flush),
    .err_clear_i(errc), .call_data_i(cdata), .ret_data_o(rd0), .ret_valid_o(rv0),
    .top_data_o(td0), .count_o(cnt0), .full_o(fu0), .empty_o(em0),
    .overflow_o(ov0), .underflow_o(un0));

  call_stack_ctrl #(.DATA_W(DW), .DEPTH(DP), .WRAP_MODE(1'b1)) u_dut1 (
    .clock_i(clk), .reset_i(rst), .call_i(call), .ret_i(ret), .flush_i(flush),
    .err_clear_i(errc), .call_data_i(cdata), .ret_data_o(rd1), .ret_valid_o(rv1),
    .top_data_o(td1), .count_o(cnt1), .full_o(fu1), .empty_o(em1),
    .overflow_o(ov1), .underflow_o(un1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus. pv=1 means a pop strobe is expected after this
  // edge with e0/e1 as the popped values for the two instances.
  task automatic step(input logic c, input logic r, input logic f, input logic e,
                      input logic [DW-1:0] d, input bit pv,
                      input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    logic [DW-1:0] x;
    call = c; ret = r; flush = f; errc = e; cdata = d;
    if (pv) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
    @(posedge clk);
    #1;
    call = 1'b0; ret = 1'b0; flush = 1'b0; errc = 1'b0;
    chk("ret_valid0", 32'(rv0), 32'(pv));
    chk("ret_valid1", 32'(rv1), 32'(pv));
    if (pv) begin
      x = q0.pop_front(); chk("ret_data0", 32'(rd0), 32'(x));
      x = q1.pop_front(); chk("ret_data1", 32'(rd1), 32'(x));
    end
  endtask

  task automatic chk_state(input string tag, input int c0, input int c1,
                           input int t0, input int t1);
    chk({tag, "_count0"}, 32'(cnt0), c0);
    chk({tag, "_count1"}, 32'(cnt1), c1);
    chk({tag, "_top0"},   32'(td0),  t0);
    chk({tag, "_top1"},   32'(td1),  t1);
    chk({tag, "_full0"},  32'(fu0),  32'(c0 == DP));
    chk({tag, "_full1"},  32'(fu1),  32'(c1 == DP));
    chk({tag, "_empty0"}, 32'(em0),  32'(c0 == 0));
    chk({tag, "_empty1"}, 32'(em1),  32'(c1 == 0));
  endtask

  task automatic chk_flags(input string tag, input int o, input int u);
    chk({tag, "_ovf0"}, 32'(ov0), o);
    chk({tag, "_ovf1"}, 32'(ov1), o);
    chk({tag, "_unf0"}, 32'(un0), u);
    chk({tag, "_unf1"}, 32'(un1), u);
  endtask

  task automatic chk_zero(input string tag);
    chk_state(tag, 0, 0, 0, 0);
    chk_flags(tag, 0, 0);
    chk({tag, "_rd0"}, 32'(rd0), 0);
    chk({tag, "_rd1"}, 32'(rd1), 0);
    chk({tag, "_rv0"}, 32'(rv0), 0);
    chk({tag, "_rv1"}, 32'(rv1), 0);
  endtask

  initial begin
    rst = 1'b1; call = 1'b0; ret = 1'b0; flush = 1'b0; errc = 1'b0; cdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Push 1,2,3 then pop 3,2,1
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0, 4'(i), 0, 0, 0);
      chk_state("push123", i, i, i, i);
    end
    step(0, 1, 0, 0, 0, 1, 4'd3, 4'd3);
    step(0, 1, 0, 0, 0, 1, 4'd2, 4'd2);
    step(0, 1, 0, 0, 0, 1, 4'd1, 4'd1);
    chk_state("pop123", 0, 0, 0, 0);

    // Push 1..5: drop vs wrap on full
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 4'(i), 0, 0, 0);
    chk_state("push5", 4, 4, 4, 5);
    chk_flags("push5", 1, 0);
    step(0, 1, 0, 0, 0, 1, 4'd4, 4'd5);
    step(0, 1, 0, 0, 0, 1, 4'd3, 4'd4);
    step(0, 1, 0, 0, 0, 1, 4'd2, 4'd3);
    step(0, 1, 0, 0, 0, 1, 4'd1, 4'd2);
    chk_state("pop4", 0, 0, 0, 0);

    // Error flag handling
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk_flags("clr_ovf", 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk_flags("underflow", 0, 1);
    chk_state("underflow", 0, 0, 0, 0);
    chk("underflow_rd_hold", 32'(rd0), 1);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk_flags("clr_unf", 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    chk_flags("clr_vs_unf", 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk_flags("clr_unf2", 0, 0);

    // Simultaneous call+ret
    step(1, 0, 0, 0, 4'h7, 0, 0, 0);
    step(1, 0, 0, 0, 4'h9, 0, 0, 0);
    step(1, 1, 0, 0, 4'hA, 1, 4'h9, 4'h9);
    chk_state("swap", 2, 2, 4'hA, 4'hA);
    step(0, 1, 0, 0, 0, 1, 4'hA, 4'hA);
    step(0, 1, 0, 0, 0, 1, 4'h7, 4'h7);
    step(1, 1, 0, 0, 4'hC, 1, 4'hC, 4'hC);
    chk_state("passthru", 0, 0, 0, 0);
    chk_flags("passthru", 0, 0);

    // Swap while full must not raise overflow
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 4'(i + 2), 0, 0, 0);
    step(1, 1, 0, 0, 4'hE, 1, 4'h5, 4'h5);
    chk_state("swap_full", 4, 4, 4'hE, 4'hE);
    chk_flags("swap_full", 0, 0);

    // Flush wins over ret; ret_data holds
    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) step(1, 0, 0, 0, 4'(i), 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    chk_state("flush", 0, 0, 0, 0);
    chk("flush_rd_hold", 32'(rd0), 5);

    // Reset wins over call
    step(1, 0, 0, 0, 4'h3, 0, 0, 0);
    rst = 1'b1;
    step(1, 0, 0, 0, 4'h5, 0, 0, 0);
    chk_zero("rst_call");
    rst = 1'b0;

    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/call_stack_ctrl.md
CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the width of each stored opcode/entry.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of entries; a power of two, >= 2.
REQ-003 Parameter WRAP_MODE, default 0, SHALL select full-stack behaviour on call: 0 = drop the push, 1 = overwrite the oldest entry.
REQ-004 Local CW = log2(DEPTH)+1 SHALL be the width of count.
REQ-005 clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 call  in  1  push request, sampled each cycle.
REQ-008 ret  in  1  pop request, sampled each cycle.
REQ-009 flush  in  1  empty the stack, sampled each cycle.
REQ-010 err_clear  in  1  clear the sticky error flags.
REQ-011 call_data  in  DATA_W  entry to push.
REQ-012 ret_data  out  DATA_W  registered popped entry.
REQ-013 ret_valid  out  1  one-cycle strobe: ret_data updated this cycle.
REQ-014 top_data  out  DATA_W  combinational peek of the top entry; 0 when empty.
REQ-015 count  out  CW  number of valid entries, 0..DEPTH.
REQ-016 full  out  1  count == DEPTH, combinational from count.
REQ-017 empty  out  1  count == 0, combinational from count.
REQ-018 overflow  out  1  sticky: call arrived while full.
REQ-019 underflow  out  1  sticky: ret arrived while empty without call.

Function
REQ-020 Priority SHALL be reset > flush > call/ret.
REQ-021 Flush SHALL set count to 0 and drive ret_valid 0 next cycle; ret_data, overflow and underflow hold; concurrent call/ret are ignored.
REQ-022 Call only, not full: call_data written at top; count+1; visible on top_data the next cycle.
REQ-023 Call only, full, WRAP_MODE=0: storage and count unchanged; overflow set.
REQ-024 Call only, full, WRAP_MODE=1: call_data becomes top, oldest entry discarded (circular base pointer advances); count stays DEPTH; overflow set.
REQ-025 Ret only, not empty: ret_data <= current top; ret_valid = 1 the following cycle for exactly one cycle; count-1.
REQ-026 Ret only, empty: ret_valid 0; ret_data holds; underflow set; count stays 0.
REQ-027 Call and ret, not empty: ret_data <= old top, ret_valid 1 next cycle, top replaced by call_data, count unchanged, no overflow even if full.
REQ-028 Call and ret, empty: ret_data <= call_data (pass-through), ret_valid 1 next cycle, count stays 0, no underflow.
REQ-029 Pop latency SHALL be exactly one cycle from the ret sample edge to the ret_valid/ret_data update; back-to-back rets SHALL produce back-to-back strobes.
REQ-030 err_clear SHALL clear overflow and underflow next cycle; an error event in the same cycle SHALL win (flag set).
REQ-031 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-032 ret_valid SHALL be 0 in every cycle not following an accepted pop per REQ-025/027/028.

Reset
REQ-033 Reset SHALL set count 0, pointers 0, ret_data 0, ret_valid 0, overflow 0, underflow 0; storage contents are not cleared and never read while empty.
REQ-034 Reset asserted mid-sequence SHALL override any same-cycle call/ret/flush; the stack is empty the following cycle.

Verification (DEPTH=4, DATA_W=4)
REQ-035 Push 1,2,3 then 3 rets -> ret_data 3,2,1 on consecutive ret_valid cycles; count 3->0; empty=1.
REQ-036 WRAP_MODE=0: push 1..5 -> count 4, full=1, overflow=1; 4 rets -> 4,3,2,1.
REQ-037 WRAP_MODE=1: push 1..5 -> count 4, overflow=1; 4 rets -> 5,4,3,2.
REQ-038 Ret on empty -> ret_valid 0, underflow=1; err_clear -> underflow=0 next cycle; err_clear with ret on empty -> underflow stays 1.
REQ-039 Stack holds 7,9; call=1,ret=1,call_data=A -> ret_data=9, ret_valid=1, count 2, top_data=A; on empty, call_data=C -> ret_data=C, count 0.
REQ-040 Stack holds 3 entries; flush with ret -> count 0, ret_valid 0; reset with call -> count 0, all outputs 0.
